// File: rtl/clock_pkg.sv
// Shared time-of-day types, limits and wrap-around increment helpers for the
// alarm clock datapath.
package clock_pkg;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } time_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } ring_state_t;

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h >= MAX_HOUR) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m >= MAX_MIN) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] inc_sec(input logic [5:0] s);
    return (s >= MAX_SEC) ? 6'd0 : s + 6'd1;
  endfunction

  // One-second advance with carry; 23:59:59 rolls over to 00:00:00.
  function automatic time_t tick_time(input time_t t);
    time_t r;
    r = t;
    r.seconds = inc_sec(t.seconds);
    if (t.seconds >= MAX_SEC) begin
      r.minutes = inc_min(t.minutes);
      if (t.minutes >= MAX_MIN) r.hours = inc_hour(t.hours);
    end
    return r;
  endfunction

endpackage

// File: rtl/hms_counter.sv
// 1 Hz prescaler plus hh:mm:ss timekeeper. A tick that collides with a
// manual edit is held for one cycle so no second is ever dropped.
module hms_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  inc_hr,
  input  logic  inc_mn,
  output time_t cur_time,
  output time_t cur_time_nxt,
  output logic  sec_strobe
);

  localparam int            PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          pending;
  logic          edit;
  logic          advance;

  assign tick    = (pre_cnt == LAST);
  assign edit    = inc_hr | inc_mn;
  assign advance = (tick | pending) & ~edit;

  always_comb begin
    cur_time_nxt = cur_time;
    if (edit) begin
      if (inc_hr) cur_time_nxt.hours   = inc_hour(cur_time.hours);
      if (inc_mn) cur_time_nxt.minutes = inc_min(cur_time.minutes);
    end else if (advance) begin
      cur_time_nxt = tick_time(cur_time);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt    <= '0;
      pending    <= 1'b0;
      sec_strobe <= 1'b0;
      cur_time   <= '0;
    end else begin
      pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
      pending    <= edit & (tick | pending);
      sec_strobe <= advance;
      cur_time   <= cur_time_nxt;
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// Top-level alarm clock: timekeeper, editable alarm bank with lowest-index
// match priority, and the ring/snooze/auto-off state machine.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int  CLK_FREQ   = 100_000_000,
  parameter int  NUM_ALARMS = 4,
  parameter int  SNOOZE_MIN = 5,
  parameter int  RING_SEC   = 60,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [1:0]            edit_btns,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze_btn,
  input  logic                  stop_btn,
  output logic                  alarm,
  output logic [SEL_W-1:0]      alarm_id,
  output logic                  snoozed,
  output logic [16:0]           disp_time
);

  localparam int               SNZ_LOAD  = SNOOZE_MIN * 60;
  localparam int               SNZ_W     = $clog2(SNZ_LOAD + 1);
  localparam logic [SNZ_W-1:0] SNZ_INIT  = SNZ_W'(SNZ_LOAD);
  localparam logic [7:0]       RING_LAST = 8'(RING_SEC);

  logic [1:0] edit_q;
  logic       snooze_q, stop_q;
  logic [1:0] edit_edge;
  logic       snooze_edge, stop_edge;
  logic       sel_ok;

  assign edit_edge   = edit_btns & ~edit_q;
  assign snooze_edge = snooze_btn & ~snooze_q;
  assign stop_edge   = stop_btn & ~stop_q;
  assign sel_ok      = (int'(alarm_sel) < NUM_ALARMS);

  time_t cur_time, cur_time_nxt;
  logic  sec_strobe;

  hms_counter #(.CLK_FREQ(CLK_FREQ)) u_hms (
    .clk          (clk),
    .reset        (reset),
    .inc_hr       (edit_edge[1] & ~mode),
    .inc_mn       (edit_edge[0] & ~mode),
    .cur_time     (cur_time),
    .cur_time_nxt (cur_time_nxt),
    .sec_strobe   (sec_strobe)
  );

  logic [4:0] al_hh     [NUM_ALARMS];
  logic [5:0] al_mm     [NUM_ALARMS];
  logic [4:0] al_hh_nxt [NUM_ALARMS];
  logic [5:0] al_mm_nxt [NUM_ALARMS];

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      al_hh_nxt[i] = al_hh[i];
      al_mm_nxt[i] = al_mm[i];
      if (mode && sel_ok && int'(alarm_sel) == i) begin
        if (edit_edge[1]) al_hh_nxt[i] = inc_hour(al_hh[i]);
        if (edit_edge[0]) al_mm_nxt[i] = inc_min(al_mm[i]);
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  logic             hit;
  logic [SEL_W-1:0] hit_id;
  logic             match;

  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en[i] && cur_time.hours == al_hh[i] &&
          cur_time.minutes == al_mm[i] && cur_time.seconds == 6'd0) begin
        hit    = 1'b1;
        hit_id = SEL_W'(i);
      end
    end
  end

  assign match = hit & sec_strobe;

  ring_state_t      state, state_nxt;
  logic [7:0]       ring_cnt, ring_cnt_nxt;
  logic [SNZ_W-1:0] snz_cnt, snz_cnt_nxt;
  logic [SEL_W-1:0] id_q, id_nxt;
  logic             slot_off;
  logic [16:0]      disp_nxt;

  assign slot_off = ~alarm_en[id_q];
  assign alarm_id = id_q;

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    snz_cnt_nxt  = snz_cnt;
    id_nxt       = id_q;
    case (state)
      IDLE: begin
        if (match) begin
          state_nxt    = RINGING;
          id_nxt       = hit_id;
          ring_cnt_nxt = '0;
        end
      end
      RINGING: begin
        if (slot_off || stop_edge) begin
          state_nxt = IDLE;
        end else if (snooze_edge) begin
          state_nxt   = SNOOZED;
          snz_cnt_nxt = SNZ_INIT;
        end else if (sec_strobe) begin
          if (ring_cnt + 8'd1 >= RING_LAST) state_nxt = IDLE;
          else                              ring_cnt_nxt = ring_cnt + 8'd1;
        end
      end
      SNOOZED: begin
        if (slot_off || stop_edge) begin
          state_nxt = IDLE;
        end else if (match) begin
          state_nxt    = RINGING;
          id_nxt       = hit_id;
          ring_cnt_nxt = '0;
        end else if (sec_strobe) begin
          if (snz_cnt <= SNZ_W'(1)) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
            snz_cnt_nxt  = '0;
          end else begin
            snz_cnt_nxt = snz_cnt - SNZ_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display is built from next-state values so an edit shows one cycle later.
  always_comb begin
    disp_nxt = '0;
    if (!mode)       disp_nxt = cur_time_nxt;
    else if (sel_ok) disp_nxt = {al_hh_nxt[alarm_sel], al_mm_nxt[alarm_sel], 6'd0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      edit_q    <= '0;
      snooze_q  <= 1'b0;
      stop_q    <= 1'b0;
      state     <= IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      id_q      <= '0;
      alarm     <= 1'b0;
      snoozed   <= 1'b0;
      disp_time <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hh[i] <= '0;
        al_mm[i] <= '0;
      end
    end else begin
      edit_q    <= edit_btns;
      snooze_q  <= snooze_btn;
      stop_q    <= stop_btn;
      state     <= state_nxt;
      ring_cnt  <= ring_cnt_nxt;
      snz_cnt   <= snz_cnt_nxt;
      id_q      <= id_nxt;
      alarm     <= (state_nxt == RINGING);
      snoozed   <= (state_nxt == SNOOZED);
      disp_time <= disp_nxt;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hh[i] <= al_hh_nxt[i];
        al_mm[i] <= al_mm_nxt[i];
      end
    end
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised alarm clock with an internal 1 Hz prescaler and a 24 h hh:mm:ss timekeeper. It holds a bank of `NUM_ALARMS` independently enabled alarms and a ring/snooze/auto-off state machine. It is the next-generation top-level timekeeping block: it replaces the single-alarm clock and drives the seven-segment display path and the buzzer.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, clock cycles per second tick
- `NUM_ALARMS`, 4, number of alarm slots (1..16)
- `SNOOZE_MIN`, 5, snooze length in minutes (1..59)
- `RING_SEC`, 60, unanswered ring duration before auto-off (1..255)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `mode`  in  1  0 = clock edit/display, 1 = alarm edit/display
- `alarm_sel`  in  `$clog2(NUM_ALARMS)` (min 1)  alarm slot targeted in mode 1
- `edit_btns`  in  2  debounced levels; [1] = hours+, [0] = minutes+
- `alarm_en`  in  `NUM_ALARMS`  per-slot enable, level
- `snooze_btn`  in  1  debounced level
- `stop_btn`  in  1  debounced level
- `alarm`  out  1  high while ringing
- `alarm_id`  out  `$clog2(NUM_ALARMS)`  slot that caused the current ring/snooze
- `snoozed`  out  1  high while in snooze
- `disp_time`  out  17  {hours[4:0], minutes[5:0], seconds[5:0]}

## Operation
- All button inputs are rising-edge detected internally; edge = level & ~level_q.
- Prescaler: counts 0..CLK_FREQ-1 and emits a one-cycle `tick` on wrap.
- Timekeeper: on `tick`, seconds+1 with carry into minutes and hours; 23:59:59 wraps to 00:00:00.
- Edits in mode 0:
  - hours+ does 23 -> 0; minutes+ does 59 -> 0.
  - No carry between fields; seconds are untouched.
  - If an edit edge and a `tick` coincide, the edit is applied and the tick is deferred exactly one cycle (pending flag). No second is lost.
- Edits in mode 1 go to slot `alarm_sel` with the same wrap rules. Alarm seconds are always 0.
- If `alarm_sel` >= `NUM_ALARMS`, the edit is ignored and `disp_time` shows 0.
- Display: mode 0 shows the current time; mode 1 shows {alarm hh, alarm mm, 6'd0} of `alarm_sel`.
- Match: evaluated only in the cycle after a tick updates the time (`sec_strobe`). A match is current time == hh:mm:00 of an enabled slot. If several slots match, the lowest index wins.
- FSM, states IDLE, RINGING, SNOOZED:
  - IDLE -> RINGING on match. `alarm_id` is latched and the ring counter is cleared.
  - RINGING:
    - The ring counter counts ticks; reaching `RING_SEC` -> IDLE.
    - stop edge -> IDLE.
    - snooze edge -> SNOOZED, snooze counter loaded with SNOOZE_MIN*60.
    - stop and snooze edges in the same cycle: stop wins.
    - New matches are ignored.
  - SNOOZED:
    - The snooze counter decrements on tick; at 0 -> RINGING with the ring counter cleared.
    - stop edge -> IDLE.
    - A new match -> RINGING with the new `alarm_id`.
  - In RINGING or SNOOZED, if `alarm_en[alarm_id]` is deasserted -> IDLE next cycle.
  - Editing the active slot does not affect the FSM.
- Reset (any time, including mid-ring or mid-edit):
  - Time 00:00:00; all alarms 00:00; prescaler 0; FSM IDLE; pending flag 0.
  - Edge registers cleared.
  - Outputs: `alarm`=0, `alarm_id`=0, `snoozed`=0, `disp_time`=0.

## Timing
- Edit latency: edge sampled in cycle N; `disp_time` shows the new value in cycle N+1.
- Tick in cycle T: time register updates at end of T, `sec_strobe` is high in T+1, `alarm` rises in T+2.
- `alarm` and `snoozed` are registered FSM decodes. They fall the cycle after the stop edge is sampled.
- `disp_time` is registered. A `mode` or `alarm_sel` change is visible one cycle later.

## Structure
- Package `clock_pkg`:
  - `time_t` packed struct {hours[4:0], minutes[5:0], seconds[5:0]}.
  - `ring_state_t` enum {IDLE, RINGING, SNOOZED}.
  - Constants `MAX_HOUR`=23, `MAX_MIN`=59, `MAX_SEC`=59.
  - Increment functions with wrap.
- Sub-module `hms_counter`: prescaler + timekeeper + deferred-tick logic. Outputs `time_t` and `sec_strobe`.
- The alarm bank, match priority and FSM stay in the top.

## Test plan
All scenarios use CLK_FREQ=4, NUM_ALARMS=4, SNOOZE_MIN=1, RING_SEC=3.
- Wrap: edit time to 23:59:57, run 3 s -> `disp_time` = 00:00:00. Hours+ at 23 -> 0 with minutes unchanged.
- Ring and auto-off: slot 2 = 07:30, enabled; time 07:29:58 -> after 2 ticks `alarm`=1 (2 cycles after the tick), `alarm_id`=2. After 3 more ticks `alarm`=0.
- Priority and snooze:
  - Slots 1 and 3 both 06:00, enabled -> `alarm_id`=1.
  - Snooze edge -> `snoozed`=1. After 60 ticks `alarm`=1 again.
  - Simultaneous stop+snooze -> IDLE.
- Edit/tick collision: minutes+ edge in the same cycle as a tick at 10:15:20 -> 10:16:20, then 10:16:21 one cycle later.
- Disable/reset: disable `alarm_en[alarm_id]` while ringing -> `alarm`=0 next cycle. Assert `reset`=0 mid-snooze -> all outputs 0 and time 00:00:00 next cycle.
